// File: rtl/quad_pkg.sv
// Shared RemoteComm/QuadCopter definitions: opcodes, response byte, FSM state
// and error enums, and the flight-script entry layout.
package quad_pkg;

    localparam int         DWELL_W    = 16;
    localparam logic [7:0] ACK_BYTE   = 8'hA5;

    localparam logic [7:0] OP_STPTCH  = 8'h02;
    localparam logic [7:0] OP_STRLL   = 8'h03;
    localparam logic [7:0] OP_STYW    = 8'h04;
    localparam logic [7:0] OP_STTHRST = 8'h05;
    localparam logic [7:0] OP_CAL     = 8'h06;
    localparam logic [7:0] OP_EMER    = 8'h07;
    localparam logic [7:0] OP_MTSOFF  = 8'h08;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_NAK     = 2'b10,
        ERR_ABORT   = 2'b11
    } err_code_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_WAIT_SENT,
        S_WAIT_RESP,
        S_DWELL,
        S_EMER_SEND,
        S_EMER_SENT,
        S_EMER_RESP
    } state_t;

    typedef struct packed {
        logic [7:0]         cmd;
        logic [15:0]        data;
        logic [DWELL_W-1:0] dwell;
        logic               last;
    } script_entry_t;

endpackage

// File: rtl/script_ram.sv
// Flight-script storage: one write port, registered read port, no reset
// (contents are undefined until written).
module script_ram
    import quad_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  script_entry_t i_wr_entry,
    input  logic [AW-1:0] i_rd_addr,
    output script_entry_t o_rd_entry
);

    script_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_entry;
        end
        o_rd_entry <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/flight_script_seq.sv
// Flight-script scheduler feeding RemoteComm: send, ack, dwell per entry, with
// timeout/NAK retries and an emergency-stop fallback.
module flight_script_seq
    import quad_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter int         PRESCALE  = 50000,
    parameter int         TO_CYC    = 1000000,
    parameter int         MAX_RETRY = 2,
    parameter logic [7:0] ACK       = ACK_BYTE,
    parameter int         AW        = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [7:0]         wr_cmd,
    input  logic [15:0]        wr_data,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic               wr_last,
    input  logic               start,
    input  logic               abort,
    output logic [7:0]         cmd,
    output logic [15:0]        data,
    output logic               send_cmd,
    input  logic               cmd_sent,
    input  logic               resp_rdy,
    input  logic [7:0]         resp,
    output logic               clr_resp_rdy,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [1:0]         err_code,
    output logic [AW-1:0]      step
);

    localparam int DCW = DWELL_W + $clog2(PRESCALE);
    localparam int TCW = $clog2(TO_CYC + 1);
    localparam int RCW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t             r_state;
    logic [AW-1:0]      r_step;
    logic [7:0]         r_cmd;
    logic [15:0]        r_data;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_last;
    logic               r_send_cmd;
    logic               r_done;
    logic               r_fail;
    err_code_t          r_err;
    logic               r_abort_pend;
    logic [TCW-1:0]     r_to_cnt;
    logic [DCW-1:0]     r_dwell_cnt;
    logic [RCW-1:0]     r_retry;

    logic [AW-1:0]      w_step_inc;
    logic [AW-1:0]      w_rd_addr;
    script_entry_t      w_rd_entry;
    script_entry_t      w_wr_entry;
    logic               w_wr_en;
    logic               w_timeout;
    logic               w_retry_ok;
    logic [DCW-1:0]     w_dwell_load;

    assign w_step_inc   = (r_step == AW'(DEPTH - 1)) ? r_step : r_step + AW'(1);
    // Address the RAM one cycle ahead so FETCH sees entry[step] for the step it enters with
    assign w_rd_addr    = (r_state == S_IDLE)  ? '0 :
                          (r_state == S_DWELL) ? w_step_inc : r_step;
    assign w_wr_en      = wr_en && (r_state == S_IDLE);
    assign w_wr_entry   = '{cmd: wr_cmd, data: wr_data, dwell: wr_dwell, last: wr_last};
    assign w_timeout    = (r_to_cnt == '0);
    assign w_retry_ok   = (r_retry < RCW'(MAX_RETRY));
    assign w_dwell_load = DCW'(r_dwell) * DCW'(PRESCALE);

    script_ram #(.DEPTH(DEPTH), .AW(AW)) u_script_ram (
        .clk        (clk),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_entry (w_wr_entry),
        .i_rd_addr  (w_rd_addr),
        .o_rd_entry (w_rd_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_step       <= '0;
            r_cmd        <= '0;
            r_data       <= '0;
            r_dwell      <= '0;
            r_last       <= 1'b0;
            r_send_cmd   <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_err        <= ERR_NONE;
            r_abort_pend <= 1'b0;
            r_to_cnt     <= '0;
            r_dwell_cnt  <= '0;
            r_retry      <= '0;
        end else begin
            r_send_cmd <= 1'b0;
            r_done     <= 1'b0;
            if (r_to_cnt != '0) begin
                r_to_cnt <= r_to_cnt - TCW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_fail       <= 1'b0;
                        r_err        <= ERR_NONE;
                        r_step       <= '0;
                        r_abort_pend <= 1'b0;
                        r_state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_cmd   <= w_rd_entry.cmd;
                    r_data  <= w_rd_entry.data;
                    r_dwell <= w_rd_entry.dwell;
                    r_last  <= w_rd_entry.last;
                    r_retry <= '0;
                    if (abort) begin
                        r_err   <= ERR_ABORT;
                        r_state <= S_EMER_SEND;
                    end else begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    // send_cmd and the timeout start on the same edge
                    if (abort) begin
                        r_err   <= ERR_ABORT;
                        r_retry <= '0;
                        r_state <= S_EMER_SEND;
                    end else begin
                        r_send_cmd <= 1'b1;
                        r_to_cnt   <= TCW'(TO_CYC);
                        r_state    <= S_WAIT_SENT;
                    end
                end
                S_WAIT_SENT: begin
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                        r_err        <= ERR_ABORT;
                    end
                    if (cmd_sent || w_timeout) begin
                        if (abort || r_abort_pend) begin
                            r_retry <= '0;
                            r_state <= S_EMER_SEND;
                        end else if (cmd_sent) begin
                            r_state <= S_WAIT_RESP;
                        end else if (w_retry_ok) begin
                            r_retry <= r_retry + RCW'(1);
                            r_state <= S_SEND;
                        end else begin
                            r_err   <= ERR_TIMEOUT;
                            r_retry <= '0;
                            r_state <= S_EMER_SEND;
                        end
                    end
                end
                S_WAIT_RESP: begin
                    if (abort) begin
                        r_err   <= ERR_ABORT;
                        r_retry <= '0;
                        r_state <= S_EMER_SEND;
                    end else if (resp_rdy && resp == ACK) begin
                        r_dwell_cnt <= w_dwell_load;
                        r_state     <= S_DWELL;
                    end else if (resp_rdy || w_timeout) begin
                        if (w_retry_ok) begin
                            r_retry <= r_retry + RCW'(1);
                            r_state <= S_SEND;
                        end else begin
                            r_err   <= resp_rdy ? ERR_NAK : ERR_TIMEOUT;
                            r_retry <= '0;
                            r_state <= S_EMER_SEND;
                        end
                    end
                end
                S_DWELL: begin
                    if (abort) begin
                        r_err   <= ERR_ABORT;
                        r_retry <= '0;
                        r_state <= S_EMER_SEND;
                    end else if (r_dwell_cnt <= DCW'(1)) begin
                        if (r_last || r_step == AW'(DEPTH - 1)) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_step  <= w_step_inc;
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt - DCW'(1);
                    end
                end
                S_EMER_SEND: begin
                    r_cmd      <= OP_EMER;
                    r_data     <= '0;
                    r_send_cmd <= 1'b1;
                    r_to_cnt   <= TCW'(TO_CYC);
                    r_state    <= S_EMER_SENT;
                end
                S_EMER_SENT: begin
                    if (cmd_sent) begin
                        r_state <= S_EMER_RESP;
                    end else if (w_timeout) begin
                        if (w_retry_ok) begin
                            r_retry <= r_retry + RCW'(1);
                            r_state <= S_EMER_SEND;
                        end else begin
                            r_fail  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_EMER_RESP: begin
                    if ((resp_rdy && resp == ACK) || ((resp_rdy || w_timeout) && !w_retry_ok)) begin
                        r_fail  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (resp_rdy || w_timeout) begin
                        r_retry <= r_retry + RCW'(1);
                        r_state <= S_EMER_SEND;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd          = r_cmd;
    assign data         = r_data;
    assign send_cmd     = r_send_cmd;
    assign clr_resp_rdy = resp_rdy && (r_state == S_WAIT_RESP || r_state == S_EMER_RESP);
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign fail         = r_fail;
    assign err_code     = r_err;
    assign step         = r_step;

endmodule

// File: tb/tb_flight_script_seq.sv
// Directed bench for flight_script_seq with a small RemoteComm responder model.
module tb_flight_script_seq;

    localparam int AW = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [7:0]  wr_cmd = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] wr_dwell = '0;
    logic        wr_last = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        send_cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        clr_resp_rdy;
    logic        busy;
    logic        done;
    logic        fail;
    logic [1:0]  err_code;
    logic [2:0]  step;

    int checks = 0;
    int failures = 0;

    // responder configuration (written by the test sequence only)
    bit silent = 1'b0;
    int sent_dly = 2;
    int nak_limit = 0;

    // responder/monitor state (each written by its own process only)
    int          n_sends = 0;
    int          n_naks = 0;
    int          n_overlap = 0;
    int          phase = 0;
    int          cnt = 0;
    logic [7:0]  log_cmd [128];
    logic [15:0] log_data [128];
    int          n_done = 0;
    int          n_clr = 0;

    flight_script_seq #(
        .DEPTH(8), .PRESCALE(3), .TO_CYC(40), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_cmd(wr_cmd), .wr_data(wr_data), .wr_dwell(wr_dwell), .wr_last(wr_last),
        .start(start), .abort(abort), .cmd(cmd), .data(data), .send_cmd(send_cmd),
        .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
        .clr_resp_rdy(clr_resp_rdy), .busy(busy), .done(done), .fail(fail),
        .err_code(err_code), .step(step)
    );

    always #5 clk = ~clk;

    // RemoteComm model: frame -> cmd_sent after sent_dly -> response 2 cycles later
    always @(negedge clk) begin
        if (!rst_n) begin
            phase    = 0;
            cmd_sent = 1'b0;
            resp_rdy = 1'b0;
            resp     = 8'h00;
        end else if (send_cmd === 1'b1) begin
            if (phase == 1) n_overlap++;
            log_cmd[n_sends & 127]  = cmd;
            log_data[n_sends & 127] = data;
            n_sends++;
            cmd_sent = 1'b0;
            resp_rdy = 1'b0;
            cnt      = sent_dly;
            phase    = silent ? 0 : 1;
        end else begin
            case (phase)
                1: begin
                    cnt--;
                    if (cnt <= 0) begin cmd_sent = 1'b1; phase = 2; end
                end
                2: begin cmd_sent = 1'b0; cnt = 2; phase = 3; end
                3: begin
                    cnt--;
                    if (cnt <= 0) begin
                        if (n_naks < nak_limit) begin resp = 8'h00; n_naks++; end
                        else resp = 8'hA5;
                        resp_rdy = 1'b1;
                        phase = 4;
                    end
                end
                4: begin resp_rdy = 1'b0; phase = 0; end
                default: phase = 0;
            endcase
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (done === 1'b1) n_done++;
        if (clr_resp_rdy === 1'b1) n_clr++;
    end

    task automatic write_entry(input logic [2:0] a, input logic [7:0] c, input logic [15:0] d,
                               input logic [15:0] dw, input logic l);
        @(negedge clk);
        wr_addr = a; wr_cmd = c; wr_data = d; wr_dwell = dw; wr_last = l; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_basic_script();
        write_entry(3'd0, 8'h06, 16'h0000, 16'd5, 1'b0);
        write_entry(3'd1, 8'h05, 16'h00FF, 16'd5, 1'b0);
        write_entry(3'd2, 8'h02, 16'h0100, 16'd5, 1'b0);
        write_entry(3'd3, 8'h08, 16'h0000, 16'd5, 1'b1);
        write_entry(3'd4, 8'h04, 16'hDEAD, 16'd1, 1'b0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        if (k >= limit) begin
            checks++; failures++;
            $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, limit);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (send_cmd !== 1'b0) begin failures++; $display("FAIL reset_send: got %b want 0", send_cmd); end
        checks++; if (cmd !== 8'h00)     begin failures++; $display("FAIL reset_cmd: got %h want 00", cmd); end
        checks++; if (data !== 16'h0)    begin failures++; $display("FAIL reset_data: got %h want 0000", data); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (fail !== 1'b0)     begin failures++; $display("FAIL reset_fail: got %b want 0", fail); end
        checks++; if (err_code !== 2'b00) begin failures++; $display("FAIL reset_err: got %b want 00", err_code); end
        checks++; if (step !== 3'd0)     begin failures++; $display("FAIL reset_step: got %0d want 0", step); end
        checks++; if (clr_resp_rdy !== 1'b0) begin failures++; $display("FAIL reset_clr: got %b want 0", clr_resp_rdy); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_script();
        int s0, d0, c0;
        logic [7:0]  exp_c [4];
        logic [15:0] exp_d [4];
        exp_c = '{8'h06, 8'h05, 8'h02, 8'h08};
        exp_d = '{16'h0000, 16'h00FF, 16'h0100, 16'h0000};
        load_basic_script();
        s0 = n_sends; d0 = n_done; c0 = n_clr;
        pulse_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_idle("basic_idle", 1000);
        checks++; if (n_sends - s0 !== 4) begin failures++; $display("FAIL basic_frames: got %0d want 4", n_sends - s0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_cmd[(s0 + i) & 127] !== exp_c[i] || log_data[(s0 + i) & 127] !== exp_d[i]) begin
                failures++;
                $display("FAIL basic_frame%0d: got %h/%h want %h/%h", i,
                         log_cmd[(s0 + i) & 127], log_data[(s0 + i) & 127], exp_c[i], exp_d[i]);
            end
        end
        checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL basic_done: got %0d pulses want 1", n_done - d0); end
        checks++; if (n_clr - c0 !== 4)  begin failures++; $display("FAIL basic_clr: got %0d pulses want 4", n_clr - c0); end
        checks++; if (fail !== 1'b0)     begin failures++; $display("FAIL basic_fail: got %b want 0", fail); end
        checks++; if (step !== 3'd3)     begin failures++; $display("FAIL basic_step: got %0d want 3", step); end
    endtask

    task automatic test_nak_retry();
        int s0, d0;
        nak_limit = n_naks + 2;
        s0 = n_sends; d0 = n_done;
        pulse_start();
        wait_idle("nak_idle", 1500);
        checks++; if (n_sends - s0 !== 6) begin failures++; $display("FAIL nak_frames: got %0d want 6", n_sends - s0); end
        checks++;
        if (log_cmd[s0 & 127] !== 8'h06 || log_cmd[(s0 + 2) & 127] !== 8'h06 || log_cmd[(s0 + 3) & 127] !== 8'h05) begin
            failures++;
            $display("FAIL nak_order: got %h,%h,%h want 06,06,05", log_cmd[s0 & 127],
                     log_cmd[(s0 + 2) & 127], log_cmd[(s0 + 3) & 127]);
        end
        checks++; if (fail !== 1'b0)      begin failures++; $display("FAIL nak_fail: got %b want 0", fail); end
        checks++; if (err_code !== 2'b00) begin failures++; $display("FAIL nak_err: got %b want 00", err_code); end
        checks++; if (n_done - d0 !== 1)  begin failures++; $display("FAIL nak_done: got %0d want 1", n_done - d0); end
    endtask

    task automatic test_timeout();
        int s0, d0;
        silent = 1'b1;
        s0 = n_sends; d0 = n_done;
        pulse_start();
        wait_idle("timeout_idle", 3000);
        silent = 1'b0;
        checks++; if (n_sends - s0 !== 6) begin failures++; $display("FAIL timeout_frames: got %0d want 6", n_sends - s0); end
        checks++;
        if (log_cmd[(s0 + 2) & 127] !== 8'h06 || log_cmd[(s0 + 3) & 127] !== 8'h07 || log_data[(s0 + 3) & 127] !== 16'h0000) begin
            failures++;
            $display("FAIL timeout_emer: got %h then %h/%h want 06 then 07/0000", log_cmd[(s0 + 2) & 127],
                     log_cmd[(s0 + 3) & 127], log_data[(s0 + 3) & 127]);
        end
        checks++; if (fail !== 1'b1)      begin failures++; $display("FAIL timeout_fail: got %b want 1", fail); end
        checks++; if (err_code !== 2'b01) begin failures++; $display("FAIL timeout_err: got %b want 01", err_code); end
        checks++; if (n_done - d0 !== 0)  begin failures++; $display("FAIL timeout_done: got %0d want 0", n_done - d0); end
    endtask

    task automatic test_abort_wait_sent();
        int s0, d0, o0, k;
        sent_dly = 20;
        s0 = n_sends; d0 = n_done; o0 = n_overlap;
        pulse_start();
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (n_sends - s0 >= 3) break;
        end
        checks++; if (k >= 1000) begin failures++; $display("FAIL abort_reach_step2: got %0d frames want 3", n_sends - s0); end
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("abort_idle", 1000);
        sent_dly = 2;
        checks++; if (n_overlap - o0 !== 0) begin failures++; $display("FAIL abort_overlap: got %0d early sends want 0", n_overlap - o0); end
        checks++; if (n_sends - s0 !== 4)   begin failures++; $display("FAIL abort_frames: got %0d want 4", n_sends - s0); end
        checks++;
        if (log_cmd[(s0 + 3) & 127] !== 8'h07 || log_data[(s0 + 3) & 127] !== 16'h0000) begin
            failures++;
            $display("FAIL abort_emer: got %h/%h want 07/0000", log_cmd[(s0 + 3) & 127], log_data[(s0 + 3) & 127]);
        end
        checks++; if (err_code !== 2'b11) begin failures++; $display("FAIL abort_err: got %b want 11", err_code); end
        checks++; if (fail !== 1'b1)      begin failures++; $display("FAIL abort_fail: got %b want 1", fail); end
        checks++; if (n_done - d0 !== 0)  begin failures++; $display("FAIL abort_done: got %0d want 0", n_done - d0); end
        checks++; if (step !== 3'd2)      begin failures++; $display("FAIL abort_step: got %0d want 2", step); end
    endtask

    task automatic test_start_abort_and_busy_write();
        int s0;
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_abort_busy: got %b want 0", busy); end
        checks++; if (fail !== 1'b1) begin failures++; $display("FAIL start_abort_fail_kept: got %b want 1", fail); end
        pulse_start();
        repeat (3) @(negedge clk);
        write_entry(3'd0, 8'h03, 16'h1234, 16'd0, 1'b1);
        wait_idle("busywr_idle1", 1000);
        s0 = n_sends;
        pulse_start();
        wait_idle("busywr_idle2", 1000);
        checks++;
        if (log_cmd[s0 & 127] !== 8'h06 || log_data[s0 & 127] !== 16'h0000 || n_sends - s0 !== 4) begin
            failures++;
            $display("FAIL busy_write_dropped: got %h/%h frames=%0d want 06/0000 frames=4",
                     log_cmd[s0 & 127], log_data[s0 & 127], n_sends - s0);
        end
    endtask

    task automatic test_no_last();
        int s0, d0;
        for (int i = 0; i < 8; i++) write_entry(3'(i), 8'h10 + 8'(i), 16'(i * 3), 16'd0, 1'b0);
        s0 = n_sends; d0 = n_done;
        pulse_start();
        wait_idle("nolast_idle", 1500);
        checks++; if (n_sends - s0 !== 8) begin failures++; $display("FAIL nolast_frames: got %0d want 8", n_sends - s0); end
        checks++;
        if (log_cmd[(s0 + 7) & 127] !== 8'h17 || log_data[(s0 + 7) & 127] !== 16'd21) begin
            failures++;
            $display("FAIL nolast_final: got %h/%h want 17/0015", log_cmd[(s0 + 7) & 127], log_data[(s0 + 7) & 127]);
        end
        checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL nolast_done: got %0d want 1", n_done - d0); end
        checks++; if (step !== 3'd7)     begin failures++; $display("FAIL nolast_step: got %0d want 7", step); end
    endtask

    task automatic test_reset_in_dwell();
        int s0, c0, d0, k;
        load_basic_script();
        c0 = n_clr;
        pulse_start();
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (n_clr - c0 >= 2) break;
        end
        checks++; if (k >= 1000) begin failures++; $display("FAIL rst_reach_dwell: got %0d acks want 2", n_clr - c0); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || cmd !== 8'h00 || data !== 16'h0 || step !== 3'd0 || send_cmd !== 1'b0 ||
            done !== 1'b0 || fail !== 1'b0 || err_code !== 2'b00) begin
            failures++;
            $display("FAIL rst_async: got busy=%b cmd=%h data=%h step=%0d want all 0", busy, cmd, data, step);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = n_sends; d0 = n_done;
        pulse_start();
        wait_idle("rst_rerun_idle", 1000);
        checks++;
        if (n_sends - s0 !== 4 || n_done - d0 !== 1 || fail !== 1'b0) begin
            failures++;
            $display("FAIL rst_rerun: got frames=%0d done=%0d fail=%b want 4/1/0", n_sends - s0, n_done - d0, fail);
        end
    endtask

    initial begin
        test_reset();
        test_basic_script();
        test_nak_retry();
        test_timeout();
        test_abort_wait_sent();
        test_start_abort_and_busy_write();
        test_no_last();
        test_reset_in_dwell();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
